// File: rtl/wb_arbiter_2_rr_if.sv
// Wishbone bus bundle for wb_arbiter_2_rr: one request/response channel between one
// master and one slave.
interface wb_arbiter_2_rr_if #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic                    we;
  logic [SELECT_WIDTH-1:0] sel;
  logic                    stb;
  logic                    cyc;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport master (
    output adr, dat_w, we, sel, stb, cyc,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  adr, dat_w, we, sel, stb, cyc,
    output dat_r, ack, err, rty
  );
endinterface

// File: rtl/wb_arbiter_2_rr.sv
// Two-master round-robin Wishbone arbiter with a registered grant held for a whole CYC.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_2_rr #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_arbiter_2_rr_if.slave     wbm0,
  wb_arbiter_2_rr_if.slave     wbm1,
  wb_arbiter_2_rr_if.master    wbs,
  output logic                 arb_timeout_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGnt0  = 2'd1,
    StGnt1  = 2'd2
`ifdef WB_ARB_TIMEOUT_EN
    , StFlush = 2'd3
`endif
  } state_e;

  state_e state_q, state_d;
  logic   last_gnt_q, last_gnt_d;
  logic   timeout_hit;

  logic [ADDR_WIDTH-1:0]   req_adr;
  logic [DATA_WIDTH-1:0]   req_dat;
  logic [SELECT_WIDTH-1:0] req_sel;
  logic                    req_we;
  logic                    req_stb;
  logic                    req_cyc;
  logic [DATA_WIDTH-1:0]   rsp_dat;
  logic                    rsp_ack;
  logic                    rsp_err;
  logic                    rsp_rty;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            flush_idx_q, flush_idx_d;
  logic            slv_rsp;
  logic            stall;

  assign slv_rsp     = wbs.ack | wbs.err | wbs.rty;
  assign stall       = req_cyc & req_stb & ~slv_rsp;
  assign timeout_hit = ((state_q == StGnt0) || (state_q == StGnt1)) && (cnt_q == TimeoutVal);

  always_comb begin : cnt_next
    cnt_d = cnt_q;
    if ((state_d != state_q) || slv_rsp) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != TimeoutVal)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : cnt_reg
    if (!rst_n) begin
      cnt_q       <= '0;
      flush_idx_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      flush_idx_q <= flush_idx_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register; last_gnt resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin : next_state
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
`ifdef WB_ARB_TIMEOUT_EN
    flush_idx_d = flush_idx_q;
`endif
    case (state_q)
      StIdle: begin
        if (wbm0.cyc && wbm1.cyc) begin
          state_d = last_gnt_q ? StGnt0 : StGnt1;
        end else if (wbm0.cyc) begin
          state_d = StGnt0;
        end else if (wbm1.cyc) begin
          state_d = StGnt1;
        end
      end
      StGnt0: begin
        if (!wbm0.cyc) begin
          last_gnt_d = 1'b0;
          state_d    = wbm1.cyc ? StGnt1 : StIdle;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d     = StFlush;
          flush_idx_d = 1'b0;
        end
`endif
      end
      StGnt1: begin
        if (!wbm1.cyc) begin
          last_gnt_d = 1'b1;
          state_d    = wbm0.cyc ? StGnt0 : StIdle;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d     = StFlush;
          flush_idx_d = 1'b1;
        end
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      StFlush: begin
        // Aborted master must drop CYC before the bus is handed on.
        if (flush_idx_q ? !wbm1.cyc : !wbm0.cyc) begin
          last_gnt_d = flush_idx_q;
          if (flush_idx_q ? wbm0.cyc : wbm1.cyc) begin
            state_d = flush_idx_q ? StGnt0 : StGnt1;
          end else begin
            state_d = StIdle;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin : outputs
    req_adr = '0;
    req_dat = '0;
    req_sel = '0;
    req_we  = 1'b0;
    req_stb = 1'b0;
    req_cyc = 1'b0;
    rsp_dat = wbs.dat_r;
    rsp_ack = wbs.ack & ~timeout_hit;
    rsp_err = wbs.err | timeout_hit;
    rsp_rty = wbs.rty & ~timeout_hit;

    wbm0.dat_r = '0;
    wbm0.ack   = 1'b0;
    wbm0.err   = 1'b0;
    wbm0.rty   = 1'b0;
    wbm1.dat_r = '0;
    wbm1.ack   = 1'b0;
    wbm1.err   = 1'b0;
    wbm1.rty   = 1'b0;
    arb_timeout_o = timeout_hit;

    // Responses are gated with the owner's CYC so late acks after an abort are dropped.
    unique case (state_q)
      StGnt0: begin
        req_adr    = wbm0.adr;
        req_dat    = wbm0.dat_w;
        req_sel    = wbm0.sel;
        req_we     = wbm0.we;
        req_stb    = wbm0.stb;
        req_cyc    = wbm0.cyc;
        wbm0.dat_r = rsp_dat;
        wbm0.ack   = wbm0.cyc & rsp_ack;
        wbm0.err   = wbm0.cyc & rsp_err;
        wbm0.rty   = wbm0.cyc & rsp_rty;
      end
      StGnt1: begin
        req_adr    = wbm1.adr;
        req_dat    = wbm1.dat_w;
        req_sel    = wbm1.sel;
        req_we     = wbm1.we;
        req_stb    = wbm1.stb;
        req_cyc    = wbm1.cyc;
        wbm1.dat_r = rsp_dat;
        wbm1.ack   = wbm1.cyc & rsp_ack;
        wbm1.err   = wbm1.cyc & rsp_err;
        wbm1.rty   = wbm1.cyc & rsp_rty;
      end
      default: ;
    endcase
  end

  assign wbs.adr   = req_adr;
  assign wbs.dat_w = req_dat;
  assign wbs.sel   = req_sel;
  assign wbs.we    = req_we;
  assign wbs.stb   = req_stb;
  assign wbs.cyc   = req_cyc;

endmodule

// File: tb/tb_wb_arbiter_2_rr.sv
// Directed bench for wb_arbiter_2_rr; watchdog checks follow WB_ARB_TIMEOUT_EN.
module tb_wb_arbiter_2_rr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic arb_timeout;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  wb_arbiter_2_rr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4)) m0 ();
  wb_arbiter_2_rr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4)) m1 ();
  wb_arbiter_2_rr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4)) s ();

  wb_arbiter_2_rr #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .SELECT_WIDTH(4),
    .TIMEOUT     (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wbm0         (m0),
    .wbm1         (m1),
    .wbs          (s),
    .arb_timeout_o(arb_timeout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks happen at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_all();
    m0.adr = 32'h100; m0.dat_w = 32'h0A0A0A0A; m0.we = 1'b1; m0.sel = 4'hF;
    m0.stb = 1'b0;    m0.cyc = 1'b0;
    m1.adr = 32'h200; m1.dat_w = 32'h1B1B1B1B; m1.we = 1'b0; m1.sel = 4'h3;
    m1.stb = 1'b0;    m1.cyc = 1'b0;
    s.dat_r = 32'h0; s.ack = 1'b0; s.err = 1'b0; s.rty = 1'b0;
  endtask

  initial begin
    logic [31:0] adr_tab [2];
    adr_tab[0] = 32'h100;
    adr_tab[1] = 32'h200;
    idle_all();

    // Reset state
    #12;
    check("rst_wbs_cyc", 64'(s.cyc), 64'd0);
    check("rst_m0_ack", 64'(m0.ack), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: simultaneous request, master 0 first
    tick();
    m0.cyc = 1; m0.stb = 1; m1.cyc = 1; m1.stb = 1;
    sample();
    check("t1_latency_cyc", 64'(s.cyc), 64'd0);
    tick();
    s.ack = 1;
    sample();
    check("t1_gnt0_cyc", 64'(s.cyc), 64'd1);
    check("t1_gnt0_adr", 64'(s.adr), 64'h100);
    check("t1_m0_ack", 64'(m0.ack), 64'd1);
    check("t1_m1_ack", 64'(m1.ack), 64'd0);
    tick();
    m0.cyc = 0; m0.stb = 0; s.ack = 0;
    sample();
    check("t1_release_cyc", 64'(s.cyc), 64'd0);
    tick();
    s.ack = 1;
    sample();
    check("t1_gnt1_adr", 64'(s.adr), 64'h200);
    check("t1_m1_ack", 64'(m1.ack), 64'd1);
    check("t1_m0_ack_off", 64'(m0.ack), 64'd0);
    tick();
    m1.cyc = 0; m1.stb = 0; s.ack = 0;
    tick();

    // 2: four-beat burst by master 0 while master 1 waits
    m0.cyc = 1; m0.stb = 1; m1.cyc = 1; m1.stb = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      s.ack = 1;
      sample();
      check($sformatf("t2_m0_ack%0d", i), 64'(m0.ack), 64'd1);
      check($sformatf("t2_m1_ack%0d", i), 64'(m1.ack), 64'd0);
      tick();
    end
    m0.cyc = 0; m0.stb = 0; s.ack = 1;
    sample();
    check("t2_late_ack_dropped", 64'(m0.ack), 64'd0);
    check("t2_m1_still_off", 64'(m1.ack), 64'd0);
    tick();
    s.ack = 0;
    m1.cyc = 0; m1.stb = 0;
    tick();

    // 3: response in IDLE ignored; master 1 sole read
    s.ack = 1; s.dat_r = 32'h12345678;
    sample();
    check("t3_idle_m0_ack", 64'(m0.ack), 64'd0);
    check("t3_idle_m1_ack", 64'(m1.ack), 64'd0);
    check("t3_idle_m1_dat", 64'(m1.dat_r), 64'd0);
    tick();
    s.ack = 0;
    m1.adr = 32'h1000; m1.we = 0; m1.cyc = 1; m1.stb = 1;
    tick();
    s.dat_r = 32'hDEADBEEF; s.ack = 1;
    sample();
    check("t3_adr", 64'(s.adr), 64'h1000);
    check("t3_we", 64'(s.we), 64'd0);
    check("t3_m1_dat", 64'(m1.dat_r), 64'hDEADBEEF);
    check("t3_m0_dat", 64'(m0.dat_r), 64'd0);
    check("t3_m1_ack", 64'(m1.ack), 64'd1);
    tick();
    m1.cyc = 0; m1.stb = 0; s.ack = 0; s.dat_r = 0;
    m1.adr = 32'h200;
    tick();

    // 4: alternating back-to-back, 8 transfers
    m0.cyc = 1; m0.stb = 1; m1.cyc = 1; m1.stb = 1;
    tick();
    for (int k = 0; k < 8; k++) begin
      s.ack = 1;
      sample();
      check($sformatf("t4_cyc%0d", k), 64'(s.cyc), 64'd1);
      check($sformatf("t4_adr%0d", k), 64'(s.adr), 64'(adr_tab[k % 2]));
      check($sformatf("t4_ack%0d", k), 64'((k % 2 == 0) ? m0.ack : m1.ack), 64'd1);
      check($sformatf("t4_other%0d", k), 64'((k % 2 == 0) ? m1.ack : m0.ack), 64'd0);
      tick();
      s.ack = 0;
      if (k % 2 == 0) begin m0.cyc = 0; m0.stb = 0; end
      else begin m1.cyc = 0; m1.stb = 0; end
      tick();
      if (k % 2 == 0) begin m0.cyc = 1; m0.stb = 1; end
      else begin m1.cyc = 1; m1.stb = 1; end
    end
    m0.cyc = 0; m0.stb = 0; m1.cyc = 0; m1.stb = 0;
    tick();
    tick();

    // 5: asynchronous reset during GNT1
    m1.cyc = 1; m1.stb = 1;
    tick();
    sample();
    check("t5_gnt1_cyc", 64'(s.cyc), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_cyc", 64'(s.cyc), 64'd0);
    m0.cyc = 1; m0.stb = 1;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    sample();
    check("t5_post_rst_adr", 64'(s.adr), 64'h100);
    check("t5_post_rst_cyc", 64'(s.cyc), 64'd1);
    m0.cyc = 0; m0.stb = 0; m1.cyc = 0; m1.stb = 0;
    tick();
    tick();

    // 6: stalled slave
    m0.cyc = 1; m0.stb = 1;
    tick();
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      sample();
      check($sformatf("t6_no_err%0d", i), 64'(m0.err), 64'd0);
      check($sformatf("t6_no_to%0d", i), 64'(arb_timeout), 64'd0);
      tick();
    end
    sample();
    check("t6_err_pulse", 64'(m0.err), 64'd1);
    check("t6_to_pulse", 64'(arb_timeout), 64'd1);
    tick();
    sample();
    check("t6_flush_cyc", 64'(s.cyc), 64'd0);
    check("t6_flush_err", 64'(m0.err), 64'd0);
    check("t6_flush_to", 64'(arb_timeout), 64'd0);
    tick();
    s.ack = 1;
    sample();
    check("t6_flush_no_ack", 64'(m0.ack), 64'd0);
    check("t6_flush_cyc2", 64'(s.cyc), 64'd0);
    tick();
    s.ack = 0;
    m0.cyc = 0; m0.stb = 0;
    tick();
    m0.cyc = 1; m0.stb = 1;
    tick();
    sample();
    check("t6_regrant_cyc", 64'(s.cyc), 64'd1);
`else
    for (int i = 0; i < 10; i++) begin
      sample();
      check($sformatf("t6_no_err%0d", i), 64'(m0.err), 64'd0);
      check($sformatf("t6_no_to%0d", i), 64'(arb_timeout), 64'd0);
      tick();
    end
    sample();
    check("t6_grant_held", 64'(s.cyc), 64'd1);
`endif
    m0.cyc = 0; m0.stb = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
